uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one UART transmit line among NUM_REQ requesters.
//  - Round-robin grant over valid/ready byte channels.
//  - Captures the granted byte, then sequences the frame onto txd: start, data LSB-first, optional parity, stop.
//  - Emits the per-bit baud tick as tx_gated_clk.
//  - Sits between the host-side TX queues and the pad driving txd.
// PARAMETERS
//  NUM_REQ    4   number of requesters (>=2)
//  DATA_W     8   data bits per frame (matches THR_SIZE)
//  BAUD_DIV   16  clk cycles per serial bit (>=2)
//  STOP_BITS  1   stop bits per frame (1 or 2)
// PORTS
//  clk        in   1               system clock; all logic on posedge
//  rst        in   1               synchronous, active-high reset
//  req_valid  in   NUM_REQ         per-requester byte available
//  req_data   in   NUM_REQ*DATA_W  byte of requester i at [i*DATA_W +: DATA_W]
//  req_ready  out  NUM_REQ         one-hot accept strobe
//  txd        out  1               serial line, idle high
//  tx_busy    out  1               high from START through last STOP cycle
//  grant_id   out  $clog2(NUM_REQ) index of requester owning the current frame
//  tx_gated_clk out 1              1-cycle pulse at the end of each bit period
//  frame_done out  1               1-cycle pulse on the last cycle of the frame
// BEHAVIOUR
//  Reset values: txd=1; req_ready=0; tx_busy=0; grant_id=0; tx_gated_clk=0; frame_done=0.
//  Reset also sets the RR pointer to 0, so req0 has top priority first.
//  FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//  IDLE:
//   - If any req_valid, the winner is the first valid index at or after ptr, searching modulo NUM_REQ.
//   - req_ready[winner]=1 combinationally in that cycle; the handshake completes then.
//   - Byte is latched; grant_id<=winner; ptr<=winner+1 (wraps to 0).
//   - Next state is START.
//  req_ready is 0 in every non-IDLE state.
//  Requesters hold data stable while valid and not accepted. Dropping valid before accept is legal; no grant is issued.
//  Bit timer counts 0..BAUD_DIV-1 in each non-IDLE state; tx_gated_clk=1 when count==BAUD_DIV-1.
//  txd by state:
//   - START: 0
//   - DATA: shreg[0], shifted right on each tick, for DATA_W bits
//   - PARITY: parity bit
//   - STOP: 1 for STOP_BITS bit periods
//  Latency: accept in cycle N -> txd=0 from cycle N+1 (registered output).
//  Frame length is (1+DATA_W+P+STOP_BITS)*BAUD_DIV cycles, where P=1 with parity enabled.
//  frame_done coincides with the final tick of the last stop bit. The FSM then returns to IDLE.
//  Back-to-back frames: at least one IDLE cycle (txd=1) between frames.
//  Simultaneous valids: exactly one accept per frame; losers are served in RR order.
//  Reset mid-frame: on the next edge txd=1, FSM=IDLE, partial frame abandoned, no frame_done.
// CONFIGURATION
//  UART_TX_PARITY_EN defined:
//   - PARITY state inserted after DATA.
//   - Bit = ^data (even parity); P=1.
//  Not defined:
//   - DATA goes straight to STOP; P=0.
//   - No parity logic synthesized.
// TESTING
//  (defaults)
//  1. Reset, req0 valid with 0xA5
//     -> ready0 pulse. txd is 0, then 1,0,1,0,0,1,0,1, then 1, 16 clk each.
//     -> frame_done 160 cycles after START; grant_id=0.
//  2. All 4 valid constantly
//     -> accepts occur in order 0,1,2,3,0.
//     -> exactly one req_ready per frame.
//     -> >=1 idle cycle between frames.
//  3. req2 only valid, ptr=3
//     -> wraps and grants 2; next grant search starts at 3.
//  4. rst asserted at cycle 50 of a frame
//     -> txd=1 next cycle; no frame_done; next grant goes to the lowest valid index.
//  5. UART_TX_PARITY_EN, data 0x07
//     -> parity bit 1 after bit7; frame length 176 cycles.
//  6. Count tx_gated_clk pulses per frame
//     -> 10 without parity, 11 with parity.
//     -> tx_gated_clk is 0 while idle.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding a single UART transmitter: start, data LSB-first, [parity], stop.
// Optional even parity bit enabled by defining UART_TX_PARITY_EN.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned BAUD_DIV  = 16,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       txd,
    output logic                       tx_busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       tx_gated_clk,
    output logic                       frame_done
);

    localparam int unsigned IdW  = $clog2(NUM_REQ);
    localparam int unsigned CntW = $clog2(BAUD_DIV);
    localparam int unsigned BitW = (DATA_W > STOP_BITS) ? $clog2(DATA_W) : $clog2(STOP_BITS + 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_TX_PARITY_EN
        StParity,
`endif
        StStop
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [BitW-1:0]   bit_q, bit_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [IdW-1:0]    grant_q, grant_d;
    logic [IdW-1:0]    ptr_q, ptr_d;
    logic              txd_q, txd_d;
`ifdef UART_TX_PARITY_EN
    logic              par_q, par_d;
`endif

    logic              found;
    logic [IdW-1:0]    winner;
    logic [DATA_W-1:0] win_data;
    logic              tick;
    int                idx;

    // Scan from the highest offset down so the nearest valid index at or after ptr wins.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        win_data = '0;
        idx      = 0;
        for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
            idx = (int'(ptr_q) + k) % int'(NUM_REQ);
            if (req_valid[idx]) begin
                found    = 1'b1;
                winner   = IdW'(idx);
                win_data = req_data[idx*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        req_ready  = '0;
        tick       = 1'b0;
        frame_done = 1'b0;
        txd_d      = 1'b1;
`ifdef UART_TX_PARITY_EN
        par_d      = par_q;
`endif
        if (state_q != StIdle) begin
            tick  = (cnt_q == CntW'(BAUD_DIV - 1));
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                bit_d = '0;
                if (!rst && found) begin
                    req_ready[winner] = 1'b1;
                    shreg_d = win_data;
                    grant_d = winner;
                    ptr_d   = (winner == IdW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
`ifdef UART_TX_PARITY_EN
                    par_d   = ^win_data;
`endif
                    state_d = StStart;
                end
            end
            StStart: begin
                if (tick) begin
                    state_d = StData;
                    bit_d   = '0;
                end
            end
            StData: begin
                if (tick) begin
                    shreg_d = shreg_q >> 1;
                    if (bit_q == BitW'(DATA_W - 1)) begin
                        bit_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (tick) begin
                    state_d = StStop;
                    bit_d   = '0;
                end
            end
`endif
            StStop: begin
                if (tick) begin
                    if (bit_q == BitW'(STOP_BITS - 1)) begin
                        frame_done = 1'b1;
                        state_d    = StIdle;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // txd is registered, so it is derived from the state being entered.
        case (state_d)
            StStart:  txd_d = 1'b0;
            StData:   txd_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
            StParity: txd_d = par_d;
`endif
            default:  txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            grant_q <= '0;
            ptr_q   <= '0;
            txd_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            txd_q   <= txd_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign txd          = txd_q;
    assign tx_busy      = (state_q != StIdle);
    assign grant_id     = grant_q;
    assign tx_gated_clk = tick;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed frames, serial decode monitor, RR order checks.
module tb_uart_tx_arbiter;

    localparam int NReq = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBits = 11;
`else
    localparam int NBits = 10;
`endif
    localparam int FrameLen = NBits * 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_ready;
    logic        txd;
    logic        tx_busy;
    logic [1:0]  grant_id;
    logic        tx_gated_clk;
    logic        frame_done;

    uart_tx_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .txd          (txd),
        .tx_busy      (tx_busy),
        .grant_id     (grant_id),
        .tx_gated_clk (tx_gated_clk),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    int         total = 0;
    int         bad = 0;
    int         cyc_cnt = 0;
    int         last_acc_cyc = -10;
    logic [7:0] src_mem [NReq][8];
    int         src_wr [NReq];
    int         src_rd [NReq];
    logic       mon_active = 1'b0;
    int         mon_cyc = 0;
    int         done_cnt = 0;

    function automatic logic [15:0] frame_bits(input logic [7:0] d);
        logic [15:0] b;
        b = '0;
        b[0] = 1'b0;
        for (int j = 0; j < 8; j++) b[1+j] = d[j];
`ifdef UART_TX_PARITY_EN
        b[9]  = ^d;
        b[10] = 1'b1;
`else
        b[9]  = 1'b1;
`endif
        return b;
    endfunction

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic load(input int i, input logic [7:0] d);
        src_mem[i][src_wr[i] % 8] = d;
        src_wr[i]++;
    endtask

    task automatic expect_frame(input logic [1:0] id, input logic [7:0] d);
        exp_t e;
        e.id   = id;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic wait_drained(input string name, input int budget);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0 && !mon_active) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check({name, "_timeout"}, exp_q.size(), 0);
    endtask

    initial forever begin
        @(posedge clk);
        cyc_cnt++;
    end

    // Requesters: accept sampled mid-cycle, the next byte is presented after the edge.
    initial begin
        logic [3:0] acc;
        for (int i = 0; i < NReq; i++) begin
            src_wr[i] = 0;
            src_rd[i] = 0;
        end
        forever begin
            @(negedge clk);
            acc = req_valid & req_ready;
            if (req_ready != 4'b0) begin
                check("ready_onehot_valid", int'(acc == req_ready && $countones(acc) == 1), 1);
                last_acc_cyc = cyc_cnt;
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < NReq; i++) begin
                if (acc[i]) src_rd[i]++;
                req_valid[i]     = (src_rd[i] < src_wr[i]);
                req_data[i*8 +: 8] = src_mem[i][src_rd[i] % 8];
            end
        end
    end

    // Monitor: decodes each frame mid-bit and scores it against the queue head.
    initial begin
        logic [15:0] got;
        int          ticks;
        bit          gap_chk;
        exp_t        e;
        got = '0;
        ticks = 0;
        gap_chk = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (mon_active) void'(exp_q.pop_front());
                mon_active = 1'b0;
                gap_chk    = 1'b0;
            end else begin
                if (gap_chk) begin
                    check("idle_gap_txd", int'(txd), 1);
                    gap_chk = 1'b0;
                end else if (!mon_active && !txd) begin
                    mon_active = 1'b1;
                    mon_cyc    = 0;
                    ticks      = 0;
                    got        = '0;
                    check("accept_to_start_latency", cyc_cnt - last_acc_cyc, 1);
                end
                if (mon_active) begin
                    if (!tx_busy) check("busy_in_frame", int'(tx_busy), 1);
                    if (tx_gated_clk) ticks++;
                    if (mon_cyc % 16 == 8 && mon_cyc / 16 < 16) got[mon_cyc / 16] = txd;
                    if (frame_done) begin
                        done_cnt++;
                        if (exp_q.size() == 0) begin
                            check("unexpected_frame", 1, 0);
                        end else begin
                            e = exp_q.pop_front();
                            check("grant_id", int'(grant_id), int'(e.id));
                            check("frame_bits", int'(got), int'(frame_bits(e.data)));
                            check("frame_len", mon_cyc + 1, FrameLen);
                            check("tick_count", ticks, NBits);
                        end
                        mon_active = 1'b0;
                        gap_chk    = 1'b1;
                    end
                    mon_cyc++;
                end else begin
                    if (tx_gated_clk) check("idle_tick", int'(tx_gated_clk), 0);
                    if (frame_done) check("idle_frame_done", int'(frame_done), 0);
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_txd", int'(txd), 1);
        check("rst_ready", int'(req_ready), 0);
        check("rst_busy", int'(tx_busy), 0);
        check("rst_grant", int'(grant_id), 0);
        check("rst_tick", int'(tx_gated_clk), 0);
        check("rst_done", int'(frame_done), 0);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        int   dn;
        bit   hit;
        do_reset();

        // 1: single 0xA5 frame from requester 0.
        @(posedge clk);
        expect_frame(2'd0, 8'hA5);
        load(0, 8'hA5);
        wait_drained("t1", 400);

        // 2: all four contend; ptr restarts at 0 after reset.
        do_reset();
        @(posedge clk);
        expect_frame(2'd0, 8'h10);
        expect_frame(2'd1, 8'h11);
        expect_frame(2'd2, 8'h12);
        expect_frame(2'd3, 8'h13);
        expect_frame(2'd0, 8'h14);
        load(0, 8'h10);
        load(0, 8'h14);
        load(1, 8'h11);
        load(2, 8'h12);
        load(3, 8'h13);
        wait_drained("t2", 1200);

        // 3: ptr=1 -> grant 2 (ptr=3), then wrap to 2 again, then ptr=3 beats 0.
        @(posedge clk);
        expect_frame(2'd2, 8'h3C);
        load(2, 8'h3C);
        wait_drained("t3a", 400);
        @(posedge clk);
        expect_frame(2'd2, 8'hC3);
        load(2, 8'hC3);
        wait_drained("t3b", 400);
        @(posedge clk);
        expect_frame(2'd3, 8'hAA);
        expect_frame(2'd0, 8'h55);
        load(0, 8'h55);
        load(3, 8'hAA);
        wait_drained("t3c", 800);

        // 4: reset at cycle 50 of a frame.
        @(posedge clk);
        expect_frame(2'd2, 8'h5A);
        load(2, 8'h5A);
        hit = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            #1;
            if (mon_active && mon_cyc == 50) begin
                hit = 1'b1;
                break;
            end
        end
        check("t4_reached_cycle50", int'(hit), 1);
        dn = done_cnt;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("t4_txd_after_rst", int'(txd), 1);
        check("t4_busy_after_rst", int'(tx_busy), 0);
        repeat (200) @(negedge clk);
        check("t4_no_frame_done", done_cnt - dn, 0);
        check("t4_queue_flushed", exp_q.size(), 0);
        @(posedge clk);
        expect_frame(2'd1, 8'h66);
        expect_frame(2'd3, 8'h77);
        load(3, 8'h77);
        load(1, 8'h66);
        wait_drained("t4", 800);

        // 5: parity case byte (ptr now 0).
        @(posedge clk);
        expect_frame(2'd0, 8'h07);
        load(0, 8'h07);
        wait_drained("t5", 400);

        repeat (20) @(negedge clk);
        check("final_idle_txd", int'(txd), 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
